// File: rtl/bcd_scan7.sv
// Four-digit multiplexed seven-segment scan driver with frame-synchronous
// double buffering, leading-zero blanking and per-digit decimal points.
module bcd_scan7 #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_en,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);

    logic [15:0] pre_q, pre_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] shadow_bcd_q, shadow_bcd_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [15:0] disp_bcd_q, disp_bcd_d;
    logic [3:0]  disp_dp_q, disp_dp_d;
    logic        pending_q, pending_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        frame_done_q, frame_done_d;

    logic        step;
    logic        wrap;
    logic [3:0]  cur_digit;
    logic        cur_blank;
    logic        blank3, blank2, blank1;

    function automatic logic [6:0] decode7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        step  = (pre_q == PRE_MAX);
        wrap  = step && (idx_q == 2'd3);
        pre_d = step ? 16'd0 : pre_q + 16'd1;
        idx_d = step ? idx_q + 2'd1 : idx_q;
        frame_done_d = wrap;

        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        disp_bcd_d   = disp_bcd_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;
        if (load) begin
            shadow_bcd_d = bcd_in;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b1;
        end
        // A load coinciding with the wrap bypasses the shadow and leaves nothing pending.
        if (wrap) begin
            if (load) begin
                disp_bcd_d = bcd_in;
                disp_dp_d  = dp_in;
            end else if (pending_q) begin
                disp_bcd_d = shadow_bcd_q;
                disp_dp_d  = shadow_dp_q;
            end
            pending_d = 1'b0;
        end
    end

    always_comb begin
        blank3 = blank_en && (disp_bcd_q[15:12] == 4'd0);
        blank2 = blank3 && (disp_bcd_q[11:8] == 4'd0);
        blank1 = blank2 && (disp_bcd_q[7:4] == 4'd0);
        case (idx_q)
            2'd0:    begin cur_digit = disp_bcd_q[3:0];   cur_blank = 1'b0;   end
            2'd1:    begin cur_digit = disp_bcd_q[7:4];   cur_blank = blank1; end
            2'd2:    begin cur_digit = disp_bcd_q[11:8];  cur_blank = blank2; end
            default: begin cur_digit = disp_bcd_q[15:12]; cur_blank = blank3; end
        endcase
        seg_d[6:0] = cur_blank ? 7'h00 : decode7(cur_digit);
        seg_d[7]   = disp_dp_q[idx_q];
        an_d       = 4'b0001 << idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q        <= '0;
            idx_q        <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            disp_bcd_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            seg_q        <= '0;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
